// File: rtl/result_window_stats.sv
// rtl/result_window_stats.sv - windowed sum/min/max of an unstalled sample stream
// Results are held in a one-deep valid/ready register; a completed window that cannot be stored sets a sticky overrun.
module result_window_stats #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 8,
  parameter int SUMW   = WIDTH + $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SUMW-1:0]  res_sum,
  output logic [WIDTH-1:0] res_min,
  output logic [WIDTH-1:0] res_max,
  output logic             overrun
);

  localparam int CNTW = $clog2(WINDOW);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WINDOW - 1);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [SUMW-1:0]  acc_sum_q, acc_sum_d;
  logic [WIDTH-1:0] acc_min_q, acc_min_d;
  logic [WIDTH-1:0] acc_max_q, acc_max_d;
  logic [SUMW-1:0]  res_sum_q, res_sum_d;
  logic [WIDTH-1:0] res_min_q, res_min_d;
  logic [WIDTH-1:0] res_max_q, res_max_d;
  logic             overrun_q, overrun_d;

  logic             accept, first, complete, load_res;
  logic [SUMW-1:0]  new_sum;
  logic [WIDTH-1:0] new_min, new_max;

  // Running statistics including the current sample; on the last sample these are the final result.
  always_comb begin
    accept   = in_valid & ~clear;
    first    = (cnt_q == '0);
    complete = accept && (cnt_q == LAST_CNT);
    new_sum  = first ? SUMW'(in_data) : acc_sum_q + SUMW'(in_data);
    new_min  = (first || (in_data < acc_min_q)) ? in_data : acc_min_q;
    new_max  = (first || (in_data > acc_max_q)) ? in_data : acc_max_q;
    load_res = complete && ((state_q == EMPTY) || res_ready);
  end

  always_comb begin
    cnt_d     = cnt_q;
    acc_sum_d = acc_sum_q;
    acc_min_d = acc_min_q;
    acc_max_d = acc_max_q;
    if (clear) begin
      cnt_d     = '0;
      acc_sum_d = '0;
      acc_min_d = '0;
      acc_max_d = '0;
    end else if (accept) begin
      cnt_d     = complete ? '0 : cnt_q + CNTW'(1);
      acc_sum_d = new_sum;
      acc_min_d = new_min;
      acc_max_d = new_max;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (complete) state_d = FULL;
        FULL:    if (!complete && res_ready) state_d = EMPTY;
        default: state_d = EMPTY;
      endcase
    end
  end

  // A blocked result keeps the old window; the new one is dropped and flagged.
  always_comb begin
    res_sum_d = res_sum_q;
    res_min_d = res_min_q;
    res_max_d = res_max_q;
    overrun_d = overrun_q;
    if (clear) begin
      res_sum_d = '0;
      res_min_d = '0;
      res_max_d = '0;
      overrun_d = 1'b0;
    end else begin
      if (load_res) begin
        res_sum_d = new_sum;
        res_min_d = new_min;
        res_max_d = new_max;
      end
      if (complete && (state_q == FULL) && !res_ready) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      acc_sum_q <= '0;
      acc_min_q <= '0;
      acc_max_q <= '0;
      res_sum_q <= '0;
      res_min_q <= '0;
      res_max_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_sum_q <= acc_sum_d;
      acc_min_q <= acc_min_d;
      acc_max_q <= acc_max_d;
      res_sum_q <= res_sum_d;
      res_min_q <= res_min_d;
      res_max_q <= res_max_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    res_valid = (state_q == FULL);
    res_sum   = res_sum_q;
    res_min   = res_min_q;
    res_max   = res_max_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_result_window_stats.sv
// tb/tb_result_window_stats.sv - directed-vector bench for result_window_stats
module tb_result_window_stats;

  logic        clk = 1'b0;
  logic        nReset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        res_valid;
  logic        res_ready;
  logic [18:0] res_sum;
  logic [15:0] res_min;
  logic [15:0] res_max;
  logic        overrun;

  int n_checks = 0;
  int n_pass   = 0;

  result_window_stats #(.WIDTH(16), .WINDOW(8)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_min   (res_min),
    .res_max   (res_max),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic check_res(input string tag, input logic v, input logic [31:0] s,
                           input logic [31:0] mn, input logic [31:0] mx, input logic ov);
    check({tag, ".valid"},   32'(res_valid), 32'(v));
    check({tag, ".sum"},     32'(res_sum),   s);
    check({tag, ".min"},     32'(res_min),   mn);
    check({tag, ".max"},     32'(res_max),   mx);
    check({tag, ".overrun"}, 32'(overrun),   32'(ov));
  endtask

  logic [15:0] order [8] = '{16'd5, 16'd3, 16'd8, 16'd1, 16'd7, 16'd2, 16'd6, 16'd4};

  initial begin
    nReset = 1'b0; in_valid = 1'b0; in_data = '0; clear = 1'b0; res_ready = 1'b1;
    step(); step();
    check_res("reset", 1'b0, 0, 0, 0, 1'b0);
    @(negedge clk);
    nReset = 1'b1;
    step();

    // 1: 1..8 back to back
    for (int i = 1; i <= 7; i++) send(16'(i));
    check("t1.valid_before_last", 32'(res_valid), 0);
    send(16'd8);
    check_res("t1", 1'b1, 36, 1, 8, 1'b0);
    step();
    check_res("t1.consumed", 1'b0, 36, 1, 8, 1'b0);

    // 2: same values, shuffled, with idle gaps
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 3); g++) step();
      if (i == 7) check("t2.valid_before_last", 32'(res_valid), 0);
      send(order[i]);
    end
    check_res("t2", 1'b1, 36, 1, 8, 1'b0);
    step();

    // 3: all-ones then all-zeros windows
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    check_res("t3.ones", 1'b1, 32'h7FFF8, 32'hFFFF, 32'hFFFF, 1'b0);
    for (int i = 0; i < 8; i++) send(16'h0000);
    check_res("t3.zeros", 1'b1, 0, 0, 0, 1'b0);
    step();
    check("t3.consumed", 32'(res_valid), 0);

    // 4: blocked result across two windows
    res_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i));
    check_res("t4.w1", 1'b1, 36, 1, 8, 1'b0);
    for (int i = 10; i <= 17; i++) send(16'(i));
    check_res("t4.w2_dropped", 1'b1, 36, 1, 8, 1'b1);
    res_ready = 1'b1;
    step();
    check_res("t4.consumed", 1'b0, 36, 1, 8, 1'b1);
    for (int i = 20; i <= 27; i++) send(16'(i));
    check_res("t4.w3", 1'b1, 188, 20, 27, 1'b1);
    step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_res("t4.clear", 1'b0, 0, 0, 0, 1'b0);

    // 5: consume on the exact completion cycle while FULL
    res_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(16'(i));
    for (int i = 10; i <= 16; i++) send(16'(i));
    check_res("t5.held", 1'b1, 36, 1, 8, 1'b0);
    res_ready = 1'b1;
    send(16'd17);
    check_res("t5.swap", 1'b1, 108, 10, 17, 1'b0);

    // 6: async reset mid-window while FULL, then clear with a sample present
    res_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(16'(100 + i));
    check("t6.full_before_reset", 32'(res_valid), 1);
    nReset = 1'b0;
    #2;
    check_res("t6.async_reset", 1'b0, 0, 0, 0, 1'b0);
    nReset = 1'b1;
    res_ready = 1'b1;
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd99;
    step();
    clear = 1'b0; in_valid = 1'b0; in_data = '0;
    check_res("t6.clear", 1'b0, 0, 0, 0, 1'b0);
    for (int i = 2; i <= 8; i++) send(16'(i));
    check("t6.valid_before_last", 32'(res_valid), 0);
    send(16'd9);
    check_res("t6.fresh", 1'b1, 44, 2, 9, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
